// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data SRAM: CPU has fixed priority, a starvation
// counter guarantees DMA progress, and byte-lane alignment is handled on both directions.
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [1:0]        dma_size,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_ack,
    output logic              dma_err,
    output logic [31:0]       dma_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] read_lanes(input logic [31:0] rd, input logic we,
                                               input logic [1:0] size, input logic [1:0] a);
        logic [31:0] s;
        s = rd >> {a, 3'b000};
        if (we) return 32'h0;
        case (size)
            2'b00:   return {24'h0, s[7:0]};
            2'b01:   return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    state_t          state;
    logic [CNT_W-1:0] starve_cnt;
    logic            we_p0;
    logic [1:0]      size_p0;
    logic [1:0]      lane_p0;
    logic [31:0]     cpu_rdata_p2;
    logic [31:0]     dma_rdata_p2;

    logic              dma_wins;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_bad;
    logic [31:0]       resp_data;

    assign dma_wins  = dma_req && (!cpu_req || starve_cnt == LIMIT);
    assign sel_we    = dma_wins ? dma_we    : cpu_we;
    assign sel_size  = dma_wins ? dma_size  : cpu_size;
    assign sel_addr  = dma_wins ? dma_addr  : cpu_addr;
    assign sel_wdata = dma_wins ? dma_wdata : cpu_wdata;
    assign sel_bad   = misaligned(sel_size, sel_addr[1:0]);
    assign resp_data = read_lanes(sram_rdata, we_p0, size_p0, lane_p0);

    // SRAM data only arrives during RESP, so the ack cycle bypasses the hold register.
    assign cpu_rdata = cpu_ack ? resp_data : cpu_rdata_p2;
    assign dma_rdata = dma_ack ? resp_data : dma_rdata_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            owner        <= 1'b0;
            busy         <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_err      <= 1'b0;
            dma_ack      <= 1'b0;
            dma_err      <= 1'b0;
            sram_en      <= 1'b0;
            sram_we      <= 4'b0000;
            sram_addr    <= '0;
            sram_wdata   <= 32'h0;
            we_p0        <= 1'b0;
            size_p0      <= 2'b00;
            lane_p0      <= 2'b00;
            cpu_rdata_p2 <= 32'h0;
            dma_rdata_p2 <= 32'h0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            dma_ack <= 1'b0;
            dma_err <= 1'b0;
            if (!dma_req) starve_cnt <= '0;

            case (state)
                // IDLE -> ISSUE: arbitrate, latch the winner, launch the SRAM strobe
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner   <= dma_wins;
                        we_p0   <= sel_we;
                        size_p0 <= sel_size;
                        lane_p0 <= sel_addr[1:0];
                        if (sel_bad) begin
                            if (dma_wins) dma_err <= 1'b1;
                            else          cpu_err <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            sram_en    <= 1'b1;
                            sram_we    <= sel_we ? byte_en(sel_size, sel_addr[1:0]) : 4'b0000;
                            sram_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                            sram_wdata <= sel_wdata << {sel_addr[1:0], 3'b000};
                            if (dma_wins)
                                starve_cnt <= '0;
                            else if (dma_req && starve_cnt != LIMIT)
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                // ISSUE -> RESP: strobe lasts one cycle, owner's ack fires next
                ISSUE: begin
                    state   <= RESP;
                    sram_en <= 1'b0;
                    sram_we <= 4'b0000;
                    if (owner) dma_ack <= 1'b1;
                    else       cpu_ack <= 1'b1;
                end
                // RESP -> IDLE: capture the returned data for the owner only
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (cpu_ack) cpu_rdata_p2 <= resp_data;
                    if (dma_ack) dma_rdata_p2 <= resp_data;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural SRAM, scoreboard of expected responses,
// immediate assertions on lane/latency details and on every ack/err popped from the queue.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [1:0]  cpu_size, dma_size;
    logic [15:0] cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic        cpu_ack, cpu_err, dma_ack, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        busy, owner;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        is_dma;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    logic        preload;
    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_size(dma_size), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .busy(busy), .owner(owner)
    );

    // Synchronous SRAM: read word appears the cycle after sram_en.
    always @(posedge clk) begin
        if (preload) begin
            mem[2048] <= 32'h11111111;
        end else if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[sram_addr[15:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            sram_rdata <= mem[sram_addr[15:2]];
        end
    end

    // Response monitor: every ack/err must match the head of the scoreboard.
    logic [34:0] mon_obs, mon_exp;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!rst && (cpu_ack || cpu_err || dma_ack || dma_err)) begin
            mon_obs = {dma_ack | dma_err, cpu_err | dma_err, owner,
                       dma_ack ? dma_rdata : (cpu_ack ? cpu_rdata : 32'h0)};
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_resp observed=%h expected=none", mon_obs);
            end
            if (sb.size() != 0) begin
                mon_e   = sb.pop_front();
                mon_exp = {mon_e.is_dma, mon_e.err, mon_e.is_dma, mon_e.err ? 32'h0 : mon_e.rdata};
                checks++;
                assert (mon_obs === mon_exp) else begin
                    failures++;
                    $error("FAIL resp observed=%h expected=%h", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit is_dma, input logic req, input logic we,
                         input logic [1:0] size, input logic [15:0] addr, input logic [31:0] wdata);
        if (is_dma) begin
            dma_req = req; dma_we = we; dma_size = size; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    task automatic push(input bit is_dma, input bit err, input logic [31:0] rdata);
        exp_t e;
        e.is_dma = is_dma;
        e.err    = err;
        e.rdata  = rdata;
        sb.push_back(e);
    endtask

    // Single transaction from idle, with fixed-latency checks on the SRAM side.
    task automatic run_txn(input bit is_dma, input logic we, input logic [1:0] size,
                           input logic [15:0] addr, input logic [31:0] wdata, input bit exp_err,
                           input logic [31:0] exp_rdata, input logic [3:0] exp_we,
                           input logic [31:0] exp_wdata);
        push(is_dma, exp_err, exp_rdata);
        @(posedge clk); #1;
        drive(is_dma, 1'b1, we, size, addr, wdata);
        @(negedge clk);
        @(negedge clk);
        if (exp_err) begin
            check("err_pulse", {31'b0, is_dma ? dma_err : cpu_err}, 32'd1);
            check("err_no_en", {31'b0, sram_en}, 32'd0);
            if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
            @(negedge clk);
            check("err_one_cycle", {29'b0, is_dma ? dma_err : cpu_err, sram_en, busy}, 32'd0);
        end else begin
            check("issue_en_we", {27'b0, sram_en, sram_we}, {27'b0, 1'b1, exp_we});
            check("issue_addr", {16'b0, sram_addr}, {16'b0, addr[15:2], 2'b00});
            if (we) check("issue_wdata", sram_wdata, exp_wdata);
            @(negedge clk);
            check("ack_latency", {31'b0, is_dma ? dma_ack : cpu_ack}, 32'd1);
            if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
            @(negedge clk);
            check("ack_one_cycle", {30'b0, is_dma ? dma_ack : cpu_ack, busy}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {21'b0, cpu_ack, cpu_err, dma_ack, dma_err, sram_en, busy, owner, sram_we}, 32'd0);
        check({tag, "_addr_wdata"}, {16'b0, sram_addr} | sram_wdata, 32'd0);
        check({tag, "_rdata"}, cpu_rdata | dma_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        preload = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        preload = 1'b0;

        // Word write / read back, then lane tests
        run_txn(0, 1'b1, 2'b10, 16'h10F0, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF);
        run_txn(0, 1'b0, 2'b10, 16'h10F0, 32'h0, 0, 32'hDEADBEEF, 4'b0000, 32'h0);
        run_txn(0, 1'b0, 2'b01, 16'h10F2, 32'h0, 0, 32'h0000DEAD, 4'b0000, 32'h0);
        run_txn(0, 1'b1, 2'b00, 16'h10F3, 32'h000000AB, 0, 32'h0, 4'b1000, 32'hAB000000);
        run_txn(0, 1'b0, 2'b10, 16'h10F0, 32'h0, 0, 32'hABADBEEF, 4'b0000, 32'h0);
        run_txn(0, 1'b1, 2'b01, 16'h10F0, 32'h00001234, 0, 32'h0, 4'b0011, 32'h00001234);
        run_txn(0, 1'b0, 2'b10, 16'h10F0, 32'h0, 0, 32'hABAD1234, 4'b0000, 32'h0);

        // Misalignment rejections
        run_txn(0, 1'b0, 2'b10, 16'h10F1, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
        run_txn(0, 1'b0, 2'b11, 16'h10F0, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
        run_txn(0, 1'b1, 2'b01, 16'h10F3, 32'h0, 1, 32'h0, 4'b0000, 32'h0);

        // Byte read, then a DMA read; CPU rdata must hold meanwhile
        run_txn(0, 1'b0, 2'b00, 16'h10F1, 32'h0, 0, 32'h00000012, 4'b0000, 32'h0);
        run_txn(1, 1'b0, 2'b10, 16'h10F0, 32'h0, 0, 32'hABAD1234, 4'b0000, 32'h0);
        check("cpu_rdata_hold", cpu_rdata, 32'h00000012);
        check("dma_rdata_hold", dma_rdata, 32'hABAD1234);

        // Reset while a write is in ISSUE: aborted, nothing reaches memory
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 2'b10, 16'h2000, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_issue", {31'b0, sram_en}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        cpu_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_idle_busy", {31'b0, busy}, 32'd0);
        run_txn(0, 1'b0, 2'b10, 16'h2000, 32'h0, 0, 32'h11111111, 4'b0000, 32'h0);

        // Starvation: both held, grant order C,C,C,C,D repeating
        for (int k = 0; k < 10; k++) push(k % 5 == 4, 0, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 2'b10, 16'h3000, 32'h11223344);
        drive(1, 1'b1, 1'b1, 2'b10, 16'h3004, 32'h55667788);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("starve_drain", sb.size(), 32'd0);
        cpu_req = 1'b0;
        dma_req = 1'b0;

        // CPU drops its request during ISSUE; its ack still fires, then DMA is served
        push(0, 0, 32'h11223344);
        push(1, 0, 32'h55667788);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 2'b10, 16'h3000, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 16'h3004, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("drop_issue_owner", {30'b0, sram_en, owner}, 32'd2);
        cpu_req = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("drop_drain", sb.size(), 32'd0);
        dma_req = 1'b0;

        repeat (5) @(negedge clk);
        check("final_idle", {30'b0, busy, sram_en}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
